// File: rtl/sd_stream_otf_converter.sv
// On-the-fly converter: MSD-first radix-2 signed-digit stream -> two's-complement fixed point.
// Optional illegal-digit sticky flag is built only when OTFC_ERR_FLAG_EN is defined.
module sd_stream_otf_converter #(
    parameter int N_DIGITS = 8,
    parameter int CNT_W    = 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                digit_valid,
    input  logic [1:0]          digit_in,
    output logic                busy,
    output logic [CNT_W-1:0]    digit_cnt,
    output logic [N_DIGITS:0]   result,
    output logic                result_valid,
    output logic                err
);

    localparam int W = N_DIGITS + 1;
    localparam logic [W-1:0]     Q_INIT   = '0;
    localparam logic [W-1:0]     QM_INIT  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_DIGITS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t           state_r, state_nx;
    logic [W-1:0]     q_r, qm_r, q_nx, qm_nx;
    logic [W-1:0]     q_first_s, qm_first_s, q_step_s, qm_step_s;
    logic [W-1:0]     result_r, result_nx;
    logic [CNT_W-1:0] cnt_r, cnt_nx, cnt_inc_s;
    logic             busy_r, rv_r, rv_nx;
    logic             load_s;

    // Q tracks the converted value; code 11 falls into the zero-digit branch.
    function automatic logic [W-1:0] q_shift(input logic [W-1:0] q,
                                             input logic [W-1:0] qm,
                                             input logic [1:0]   d);
        case (d)
            2'b10:   q_shift = {q[W-2:0], 1'b1};
            2'b01:   q_shift = {qm[W-2:0], 1'b1};
            default: q_shift = {q[W-2:0], 1'b0};
        endcase
    endfunction

    // QM tracks Q minus one ulp at the current precision.
    function automatic logic [W-1:0] qm_shift(input logic [W-1:0] q,
                                              input logic [W-1:0] qm,
                                              input logic [1:0]   d);
        case (d)
            2'b10:   qm_shift = {q[W-2:0], 1'b0};
            2'b01:   qm_shift = {qm[W-2:0], 1'b0};
            default: qm_shift = {qm[W-2:0], 1'b1};
        endcase
    endfunction

`ifdef OTFC_ERR_FLAG_EN
    logic err_r, err_nx, illegal_s;
    assign illegal_s = (digit_in == 2'b11);
    assign err       = err_r;
`else
    assign err = 1'b0;
`endif

    // Next-state, datapath update and output-register next values.
    always_comb begin
        q_first_s  = q_shift(Q_INIT, QM_INIT, digit_in);
        qm_first_s = qm_shift(Q_INIT, QM_INIT, digit_in);
        q_step_s   = q_shift(q_r, qm_r, digit_in);
        qm_step_s  = qm_shift(q_r, qm_r, digit_in);
        cnt_inc_s  = cnt_r + CNT_ONE;
        load_s     = digit_valid && start;
        state_nx   = state_r;
        q_nx       = q_r;
        qm_nx      = qm_r;
        cnt_nx     = cnt_r;
        result_nx  = result_r;
        rv_nx      = 1'b0;
`ifdef OTFC_ERR_FLAG_EN
        err_nx     = err_r;
`endif
        if (load_s) begin
            // A start in any state begins a fresh stream; a partial one is dropped.
            q_nx   = q_first_s;
            qm_nx  = qm_first_s;
            cnt_nx = CNT_ONE;
`ifdef OTFC_ERR_FLAG_EN
            err_nx = illegal_s;
`endif
            if (CNT_ONE == CNT_LAST) begin
                state_nx  = S_DONE;
                rv_nx     = 1'b1;
                result_nx = q_first_s;
            end else begin
                state_nx = S_CONVERT;
            end
        end else begin
            case (state_r)
                S_IDLE: state_nx = S_IDLE;
                S_CONVERT: begin
                    if (digit_valid) begin
                        q_nx   = q_step_s;
                        qm_nx  = qm_step_s;
                        cnt_nx = cnt_inc_s;
`ifdef OTFC_ERR_FLAG_EN
                        err_nx = err_r | illegal_s;
`endif
                        if (cnt_inc_s == CNT_LAST) begin
                            state_nx  = S_DONE;
                            rv_nx     = 1'b1;
                            result_nx = q_step_s;
                        end else begin
                            state_nx = S_CONVERT;
                        end
                    end else begin
                        state_nx = S_CONVERT;
                    end
                end
                S_DONE:  state_nx = S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= S_IDLE;
            q_r      <= Q_INIT;
            qm_r     <= QM_INIT;
            cnt_r    <= '0;
            result_r <= '0;
            rv_r     <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_nx;
            q_r      <= q_nx;
            qm_r     <= qm_nx;
            cnt_r    <= cnt_nx;
            result_r <= result_nx;
            rv_r     <= rv_nx;
            busy_r   <= (state_nx == S_CONVERT);
        end
    end

`ifdef OTFC_ERR_FLAG_EN
    // Sticky illegal-digit flag, cleared by a new stream or reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_nx;
        end
    end
`endif

    assign busy         = busy_r;
    assign digit_cnt    = cnt_r;
    assign result       = result_r;
    assign result_valid = rv_r;

endmodule

// File: tb/tb_sd_stream_otf_converter.sv
// Self-checking bench for sd_stream_otf_converter (N_DIGITS=4): directed plan plus random streams
// checked against an arithmetic sum-of-digits reference.
module tb_sd_stream_otf_converter;

    localparam int N  = 4;
    localparam int CW = 9;
`ifdef OTFC_ERR_FLAG_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, start, digit_valid;
    logic [1:0]    digit_in;
    logic          busy, result_valid, err;
    logic [CW-1:0] digit_cnt;
    logic [N:0]    result;

    int n_checks = 0, n_fail = 0;
    int rv_count = 0, exp_pulses = 0;
    logic [N:0] last_result;
    logic [1:0] s[$];

    sd_stream_otf_converter #(.N_DIGITS(N), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .digit_valid(digit_valid),
        .digit_in(digit_in), .busy(busy), .digit_cnt(digit_cnt),
        .result(result), .result_valid(result_valid), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (result_valid === 1'b1) rv_count++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic st, input logic dv, input logic [1:0] d, input logic r);
        @(negedge clk);
        rst = r; start = st; digit_valid = dv; digit_in = d;
        @(posedge clk);
        #1;
    endtask

    function automatic int dval(input logic [1:0] c);
        case (c)
            2'b10:   return 1;
            2'b01:   return -1;
            default: return 0;
        endcase
    endfunction

    // value * 2^N as an integer, truncated to N+1 bits two's complement
    function automatic logic [N:0] ref_result(input logic [1:0] ds[$]);
        int v = 0;
        foreach (ds[j]) v = v * 2 + dval(ds[j]);
        return v[N:0];
    endfunction

    task automatic send_stream(input logic [1:0] ds[$], input int gap_pos, input int gap_len);
        bit e = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (k == gap_pos) begin
                for (int g = 0; g < gap_len; g++) begin
                    step(1'($urandom_range(0, 1)), 1'b0, 2'($urandom_range(0, 3)), 1'b0);
                    chk("gap_cnt", digit_cnt, k);
                    chk("gap_busy", busy, 1);
                    chk("gap_rv", result_valid, 0);
                end
            end
            if (ds[k] == 2'b11) e = 1'b1;
            step(k == 0, 1'b1, ds[k], 1'b0);
            chk("cnt", digit_cnt, k + 1);
            chk("err", err, ERR_EN & e);
            if (k < N - 1) begin
                chk("busy_mid", busy, 1);
                chk("rv_mid", result_valid, 0);
                chk("result_hold", result, last_result);
            end else begin
                chk("rv_done", result_valid, 1);
                chk("busy_done", busy, 0);
                chk("result", result, ref_result(ds));
            end
        end
        last_result = ref_result(ds);
        exp_pulses++;
    endtask

    task automatic idle_check();
        step(1'b0, 1'b0, 2'b00, 1'b0);
        chk("idle_rv", result_valid, 0);
        chk("idle_result", result, last_result);
        chk("idle_busy", busy, 0);
        chk("idle_cnt", digit_cnt, N);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; digit_valid = 1'b0; digit_in = 2'b00;
        last_result = '0;
        step(1'b0, 1'b0, 2'b00, 1'b1);
        step(1'b1, 1'b1, 2'b10, 1'b1);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", digit_cnt, 0);
        chk("rst_result", result, 0);
        chk("rst_rv", result_valid, 0);
        chk("rst_err", err, 0);

        // 7/16, consecutive
        s = '{2'b10, 2'b00, 2'b01, 2'b10};
        send_stream(s, -1, 0);
        chk("plan_7_16", result, 5'b00111);
        idle_check();
        // -15/16, 1/16, 0
        s = '{2'b01, 2'b01, 2'b01, 2'b01};
        send_stream(s, -1, 0);
        chk("plan_m15_16", result, 5'b10001);
        idle_check();
        s = '{2'b10, 2'b01, 2'b01, 2'b01};
        send_stream(s, -1, 0);
        chk("plan_1_16", result, 5'b00001);
        idle_check();
        s = '{2'b00, 2'b00, 2'b00, 2'b00};
        send_stream(s, -1, 0);
        chk("plan_zero", result, 5'b00000);
        idle_check();
        // gap of 3 between digits 2 and 3
        s = '{2'b10, 2'b00, 2'b01, 2'b10};
        send_stream(s, 2, 3);
        chk("plan_gap", result, 5'b00111);
        idle_check();

        // abort after 2 digits, then full stream
        step(1'b1, 1'b1, 2'b10, 1'b0);
        step(1'b0, 1'b1, 2'b00, 1'b0);
        chk("abort_cnt", digit_cnt, 2);
        s = '{2'b01, 2'b01, 2'b01, 2'b01};
        send_stream(s, -1, 0);
        chk("abort_result", result, 5'b10001);
        // back-to-back: next start lands in the DONE cycle
        s = '{2'b10, 2'b00, 2'b01, 2'b10};
        send_stream(s, -1, 0);
        chk("b2b_result", result, 5'b00111);
        idle_check();
        chk("pulses_a", rv_count, exp_pulses);

        // reset after digit 3
        step(1'b1, 1'b1, 2'b10, 1'b0);
        step(1'b0, 1'b1, 2'b11, 1'b0);
        step(1'b0, 1'b1, 2'b01, 1'b0);
        step(1'b0, 1'b1, 2'b10, 1'b1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cnt", digit_cnt, 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_rv", result_valid, 0);
        chk("mid_rst_err", err, 0);
        last_result = '0;
        step(1'b0, 1'b0, 2'b00, 1'b0);
        chk("post_rst_rv", result_valid, 0);
        // illegal digit at position 2
        s = '{2'b10, 2'b11, 2'b01, 2'b10};
        send_stream(s, -1, 0);
        chk("illegal_result", result, 5'b00111);
        idle_check();
        chk("illegal_err_sticky", err, ERR_EN);
        s = '{2'b00, 2'b10, 2'b00, 2'b01};
        send_stream(s, -1, 0);
        chk("err_cleared", err, 0);

        // random streams with gaps and back-to-back starts
        for (int t = 0; t < 30; t++) begin
            s = {};
            for (int k = 0; k < N; k++) s.push_back(2'($urandom_range(0, 3)));
            send_stream(s, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, N - 1)) : -1,
                        int'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1) idle_check();
        end
        idle_check();
        chk("pulses_total", rv_count, exp_pulses);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
